// File: rtl/imem_block_responder_pkg.sv
// imem_block_responder_pkg: shared widths and FSM encodings for the instruction-memory responder
package imem_block_responder_pkg;
  localparam int XLEN = 32;
  localparam int WORD_OFFSET = 2;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    READ = 2'd2,
    RESP = 2'd3
  } imem_state_e;
endpackage

// File: rtl/imem_block_responder_if.sv
// imem_block_responder_if: refill handshake and program-load port between cache/loader and memory
interface imem_block_responder_if
  import imem_block_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = 1
);
  logic                     data_req;
  logic [XLEN-1:0]          mem_addr;
  logic [BLOCK_SIZE*32-1:0] data_block;
  logic                     mem_ready;
  logic                     wr_en;
  logic [XLEN-1:0]          wr_addr;
  logic [31:0]              wr_data;
  modport master (
    output data_req, mem_addr, wr_en, wr_addr, wr_data,
    input  data_block, mem_ready
  );
  modport slave (
    input  data_req, mem_addr, wr_en, wr_addr, wr_data,
    output data_block, mem_ready
  );
endinterface

// File: rtl/imem_word_ram.sv
// imem_word_ram: word array with one posedge write port and one asynchronous read port
module imem_word_ram #(
  parameter int MEM_WORDS = 1024,
  localparam int AW = $clog2(MEM_WORDS)
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_idx,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_idx,
  output logic [31:0]   o_rd_data
);
  logic [31:0] mem_q [MEM_WORDS];
  // write lands on the edge, so a same-cycle read still sees the old word
  always_ff @(posedge i_clk)
    if (i_wr_en) mem_q[i_wr_idx] <= i_wr_data;
  assign o_rd_data = mem_q[i_rd_idx];
endmodule

// File: rtl/imem_block_responder.sv
// imem_block_responder: fetches a BLOCK_SIZE-word block after a fixed latency and returns it with a one-cycle ready pulse
module imem_block_responder
  import imem_block_responder_pkg::*;
#(
  parameter int BLOCK_SIZE = 1,
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  imem_block_responder_if.slave bus,
  output logic                  o_busy
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(LATENCY + BLOCK_SIZE + 1);
  localparam int BW = BLOCK_SIZE * 32;
  imem_state_e   state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] block_q, block_d;
  logic [AW-1:0] rd_idx, wr_idx;
  logic [31:0]   rd_data;
  assign rd_idx = base_q + AW'(cnt_q);
  assign wr_idx = bus.wr_addr[WORD_OFFSET +: AW];
  imem_word_ram #(.MEM_WORDS(MEM_WORDS)) u_ram (
    .i_clk     (i_clk),
    .i_wr_en   (bus.wr_en),
    .i_wr_idx  (wr_idx),
    .i_wr_data (bus.wr_data),
    .i_rd_idx  (rd_idx),
    .o_rd_data (rd_data)
  );
  // state and datapath registers; the array itself is not reset
  always_ff @(posedge i_clk)
    if (!i_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      block_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      block_q <= block_d;
    end
  // next state: a dropped request during WAIT or READ aborts back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.data_req ? ((LATENCY > 0) ? WAIT : READ) : IDLE;
      WAIT:    state_d = !bus.data_req ? IDLE : (cnt_q == CW'(LATENCY - 1)) ? READ : WAIT;
      READ:    state_d = !bus.data_req ? IDLE : (cnt_q == CW'(BLOCK_SIZE - 1)) ? RESP : READ;
      default: state_d = IDLE;
    endcase
  end
  // datapath: latch block base on acceptance, count wait cycles, capture one word per READ cycle
  always_comb begin
    base_d  = base_q;
    cnt_d   = cnt_q;
    block_d = block_q;
    if (state_q == IDLE && bus.data_req) begin
      base_d = bus.mem_addr[WORD_OFFSET +: AW] & ~AW'(BLOCK_SIZE - 1);
      cnt_d  = '0;
    end
    if (state_q == WAIT) cnt_d = (cnt_q == CW'(LATENCY - 1)) ? '0 : cnt_q + CW'(1);
    if (state_q == READ) begin
      cnt_d = cnt_q + CW'(1);
      for (int k = 0; k < BLOCK_SIZE; k++)
        if (cnt_q == CW'(k)) block_d[32*k +: 32] = rd_data;
    end
  end
  // outputs: ready only in RESP, block held until the next READ overwrites it
  always_comb begin
    bus.mem_ready  = state_q == RESP;
    bus.data_block = block_q;
    o_busy         = state_q != IDLE;
  end
endmodule

// File: tb/tb_imem_block_responder.sv
// tb_imem_block_responder: directed vectors over three responder configurations sharing one stimulus bus
module tb_imem_block_responder;
  import imem_block_responder_pkg::*;
  typedef struct {
    int           which;
    logic [31:0]  addr;
    logic [127:0] exp_data;
    logic [15:0]  exp_rdy;
    logic [15:0]  exp_busy;
  } vec_t;
  logic            i_clk = 1'b0;
  logic            rst = 1'b0;
  logic            req = 1'b0;
  logic [XLEN-1:0] mem_addr = '0;
  logic            wr_en = 1'b0;
  logic [XLEN-1:0] wr_addr = '0;
  logic [31:0]     wr_data = '0;
  logic            busy_a, busy_b, busy_c;
  int              n_chk = 0;
  int              n_fail = 0;
  always #5 i_clk = ~i_clk;
  imem_block_responder_if #(.BLOCK_SIZE(1)) a_if ();
  imem_block_responder_if #(.BLOCK_SIZE(4)) b_if ();
  imem_block_responder_if #(.BLOCK_SIZE(1)) c_if ();
  assign a_if.data_req = req;
  assign a_if.mem_addr = mem_addr;
  assign a_if.wr_en    = wr_en;
  assign a_if.wr_addr  = wr_addr;
  assign a_if.wr_data  = wr_data;
  assign b_if.data_req = req;
  assign b_if.mem_addr = mem_addr;
  assign b_if.wr_en    = wr_en;
  assign b_if.wr_addr  = wr_addr;
  assign b_if.wr_data  = wr_data;
  assign c_if.data_req = req;
  assign c_if.mem_addr = mem_addr;
  assign c_if.wr_en    = wr_en;
  assign c_if.wr_addr  = wr_addr;
  assign c_if.wr_data  = wr_data;
  imem_block_responder #(.BLOCK_SIZE(1), .MEM_WORDS(1024), .LATENCY(2)) u_a (
    .i_clk(i_clk), .i_rst(rst), .bus(a_if.slave), .o_busy(busy_a));
  imem_block_responder #(.BLOCK_SIZE(4), .MEM_WORDS(1024), .LATENCY(0)) u_b (
    .i_clk(i_clk), .i_rst(rst), .bus(b_if.slave), .o_busy(busy_b));
  imem_block_responder #(.BLOCK_SIZE(1), .MEM_WORDS(1024), .LATENCY(4)) u_c (
    .i_clk(i_clk), .i_rst(rst), .bus(c_if.slave), .o_busy(busy_c));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr_word(input int idx, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 32'(idx) << 2;
    wr_data = d;
    @(posedge i_clk); #1;
    wr_en   = 1'b0;
  endtask

  task automatic xact(input int which, input logic [31:0] addr, input int drop_cyc,
                      input int wr_cyc, input logic [31:0] wd, input int rst_cyc,
                      output logic [127:0] data, output logic [15:0] rmap,
                      output logic [15:0] bmap, output logic [127:0] snap);
    logic done, r, b;
    logic [127:0] blk;
    done = 1'b0; data = '0; rmap = '0; bmap = '0; snap = '0;
    for (int c = 0; c < 14; c++) begin
      req      = !done && (c != drop_cyc);
      mem_addr = addr;
      wr_en    = (c == wr_cyc);
      wr_addr  = addr;
      wr_data  = wd;
      rst      = (c == rst_cyc) ? 1'b0 : 1'b1;
      @(negedge i_clk);
      r   = (which == 0) ? a_if.mem_ready : (which == 1) ? b_if.mem_ready : c_if.mem_ready;
      b   = (which == 0) ? busy_a : (which == 1) ? busy_b : busy_c;
      blk = (which == 0) ? {96'b0, a_if.data_block} : (which == 1) ? b_if.data_block : {96'b0, c_if.data_block};
      bmap[c] = b;
      if (c == rst_cyc + 1) snap = blk;
      if (r) begin
        rmap[c] = 1'b1;
        data    = blk;
        done    = 1'b1;
      end
      @(posedge i_clk); #1;
    end
    req = 1'b0; wr_en = 1'b0; rst = 1'b1;
  endtask

  initial begin
    vec_t         vecs [8];
    logic [127:0] d, sn;
    logic [15:0]  rm, bm;
    vecs[0] = '{0, 32'h0000_0014, 128'hDEADBEEF, 16'h0010, 16'h001E};
    vecs[1] = '{1, 32'h0000_002C, 128'h00000044_00000033_00000022_00000011, 16'h0020, 16'h003E};
    vecs[2] = '{0, 32'h0000_100C, 128'hCAFE0003, 16'h0010, 16'h001E};
    vecs[3] = '{0, 32'h0000_0FFC, 128'hA5A50FFF, 16'h0010, 16'h001E};
    vecs[4] = '{1, 32'h0000_0020, 128'h00000044_00000033_00000022_00000011, 16'h0020, 16'h003E};
    vecs[5] = '{2, 32'h0000_0014, 128'hDEADBEEF, 16'h0040, 16'h007E};
    vecs[6] = '{0, 32'h0000_0016, 128'hDEADBEEF, 16'h0010, 16'h001E};
    vecs[7] = '{1, 32'h0000_0FF0, 128'hA5A50FFF_00000102_00000101_00000100, 16'h0020, 16'h003E};
    rst = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset a ready", {127'b0, a_if.mem_ready}, 128'd0);
    chk("reset a busy", {127'b0, busy_a}, 128'd0);
    chk("reset b block", b_if.data_block, 128'd0);
    chk("reset c busy", {127'b0, busy_c}, 128'd0);
    @(posedge i_clk); #1;
    rst = 1'b1;
    wr_word(5, 32'hDEADBEEF);
    wr_word(8, 32'h11);
    wr_word(9, 32'h22);
    wr_word(10, 32'h33);
    wr_word(11, 32'h44);
    wr_word(3, 32'hCAFE0003);
    wr_word(1020, 32'h100);
    wr_word(1021, 32'h101);
    wr_word(1022, 32'h102);
    wr_word(1023, 32'hA5A50FFF);
    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].which, vecs[i].addr, -1, -1, 32'h0, -1, d, rm, bm, sn);
      chk($sformatf("vec%0d data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d ready cycle", i), {112'b0, rm}, {112'b0, vecs[i].exp_rdy});
      chk($sformatf("vec%0d busy cycles", i), {112'b0, bm}, {112'b0, vecs[i].exp_busy});
    end
    xact(2, 32'h14, 2, -1, 32'h0, -1, d, rm, bm, sn);
    chk("drop data", d, 128'hDEADBEEF);
    chk("drop ready cycle", {112'b0, rm}, {112'b0, 16'h0200});
    chk("drop busy cycles", {112'b0, bm}, {112'b0, 16'h03F6});
    xact(1, 32'h2C, -1, -1, 32'h0, 2, d, rm, bm, sn);
    chk("midreset block cleared", sn, 128'd0);
    chk("midreset ready cycle", {112'b0, rm}, {112'b0, 16'h0100});
    chk("midreset busy cycles", {112'b0, bm}, {112'b0, 16'h01F6});
    chk("midreset data", d, 128'h00000044_00000033_00000022_00000011);
    xact(0, 32'h14, -1, 3, 32'h12345678, -1, d, rm, bm, sn);
    chk("collision old data", d, 128'hDEADBEEF);
    chk("collision ready cycle", {112'b0, rm}, {112'b0, 16'h0010});
    xact(0, 32'h14, -1, -1, 32'h0, -1, d, rm, bm, sn);
    chk("after write new data", d, 128'h12345678);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
